mod_exp_seq: RTL and testbench

- Sequential modular exponentiator: c = g^e mod r, parametrised operand and exponent width.
- Successor to the combinational mod_mul. Uses an internal bit-serial interleaved modular multiplier: one multiplier bit per clock, no wide combinational product.
- Sits under the Schnorr signer/verifier for g^k mod p and y^e mod p, driven by a start/done handshake.

---
 rtl/mod_exp_seq.sv | 159 +++++++++++++++
 tb/tb_mod_exp_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiator c = g^e mod r using a bit-serial modular multiplier.
// Define MOD_EXP_CONST_TIME_EN to run the multiply step for every exponent bit.
module mod_exp_seq #(
  parameter int LEN   = 32,
  parameter int EXP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN-1:0]   g,
  input  logic [EXP_W-1:0] e,
  input  logic [LEN-1:0]   r,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [LEN-1:0]   c
);

  localparam int KW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN-1:0]   g_q, g_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [LEN-1:0]   r_q, r_d;
  logic [LEN-1:0]   x_q, x_d;
  logic [LEN-1:0]   acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    i_q, i_d;
  logic             err_q, err_d;
  logic [LEN-1:0]   c_q, c_d;

  logic [LEN-1:0]   b_op;
  logic [LEN:0]     dbl;
  logic [LEN-1:0]   red1;
  logic [LEN:0]     sum;
  logic [LEN-1:0]   red2;
  logic [LEN-1:0]   acc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      e_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      e_q     <= e_d;
      r_q     <= r_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
      err_q   <= err_d;
      c_q     <= c_d;
    end
  end

  // One multiplier bit per cycle; acc stays below r so LEN+1 bits suffice.
  always_comb begin
    b_op   = (state_q == MUL) ? g_q : x_q;
    dbl    = {acc_q, 1'b0};
    red1   = (dbl >= {1'b0, r_q}) ? dbl[LEN-1:0] - r_q : dbl[LEN-1:0];
    sum    = {1'b0, red1} + {1'b0, x_q};
    red2   = (sum >= {1'b0, r_q}) ? sum[LEN-1:0] - r_q : sum[LEN-1:0];
    acc_nx = b_op[k_q] ? red2 : red1;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    e_d     = e_q;
    r_d     = r_q;
    x_d     = x_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    err_d   = err_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          g_d = g;
          e_d = e;
          r_d = r;
          if (r < LEN'(2) || g >= r) begin
            err_d   = 1'b1;
            c_d     = '0;
            state_d = DONE;
          end else begin
            x_d     = LEN'(1);
            acc_d   = '0;
            k_d     = KW'(LEN - 1);
            i_d     = IW'(EXP_W - 1);
            state_d = SQR;
          end
        end
      end
      SQR: begin
        acc_d = acc_nx;
        k_d   = k_q - KW'(1);
        if (k_q == '0) begin
          acc_d = '0;
          k_d   = KW'(LEN - 1);
          x_d   = acc_nx;
          if (CT || e_q[i_q]) begin
            state_d = MUL;
          end else if (i_q == '0) begin
            err_d   = 1'b0;
            c_d     = acc_nx;
            state_d = DONE;
          end else begin
            i_d = i_q - IW'(1);
          end
        end
      end
      MUL: begin
        acc_d = acc_nx;
        k_d   = k_q - KW'(1);
        if (k_q == '0) begin
          acc_d = '0;
          k_d   = KW'(LEN - 1);
          if (e_q[i_q]) x_d = acc_nx;
          if (i_q == '0) begin
            err_d   = 1'b0;
            c_d     = x_d;
            state_d = DONE;
          end else begin
            i_d     = i_q - IW'(1);
            state_d = SQR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign c     = c_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed testbench for mod_exp_seq with hand-computed results and latencies.
// Honours MOD_EXP_CONST_TIME_EN for the expected latencies.
module tb_mod_exp_seq;

  localparam int LEN   = 32;
  localparam int EXP_W = 32;
  localparam logic [31:0] P = 32'd2147483647;
  localparam int LIMIT = 5000;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int LAT_CT = 2049;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] g, e, r;
  logic        ready, done, err;
  logic [31:0] c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_exp_seq #(.LEN(LEN), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .g(g), .e(e), .r(r),
    .ready(ready), .done(done), .err(err), .c(c)
  );

  task automatic do_op(input logic [31:0] gi, ei, ri,
                       output logic [31:0] co, output logic eo,
                       output int lat);
    @(negedge clk);
    g = gi; e = ei; r = ri; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    while (!done && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
    end
    co = c;
    eo = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; g = '0; e = '0; r = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    n_cmp++; if (c !== 32'd0) begin n_bad++; $display("FAIL rst_c got=%0d exp=0", c); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] co; logic eo; int lat, xl;
    xl = CT ? LAT_CT : 1057;
    do_op(32'd3, 32'd4, P, co, eo, lat);
    n_cmp++; if (co !== 32'd81) begin n_bad++; $display("FAIL basic_c got=%0d exp=81", co); end
    n_cmp++; if (eo !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b exp=0", eo); end
    n_cmp++; if (lat != xl) begin n_bad++; $display("FAIL basic_lat got=%0d exp=%0d", lat, xl); end
  endtask

  task automatic test_fermat();
    logic [31:0] co; logic eo; int lat, xl;
    xl = CT ? LAT_CT : 1985;
    do_op(32'd290987904, 32'd2147483646, P, co, eo, lat);
    n_cmp++; if (co !== 32'd1) begin n_bad++; $display("FAIL fermat_c got=%0d exp=1", co); end
    n_cmp++; if (lat != xl) begin n_bad++; $display("FAIL fermat_lat got=%0d exp=%0d", lat, xl); end
    do_op(32'd2, 32'd31, P, co, eo, lat);
    n_cmp++; if (co !== 32'd1) begin n_bad++; $display("FAIL pow2_c got=%0d exp=1", co); end
    do_op(32'd794098883, 32'd1, P, co, eo, lat);
    n_cmp++; if (co !== 32'd794098883) begin n_bad++; $display("FAIL e1_c got=%0d exp=794098883", co); end
    n_cmp++; if (eo !== 1'b0) begin n_bad++; $display("FAIL e1_err got=%b exp=0", eo); end
  endtask

  task automatic test_edges();
    logic [31:0] co; logic eo; int lat, xl;
    xl = CT ? LAT_CT : 1025;
    do_op(32'd5, 32'd0, 32'd13, co, eo, lat);
    n_cmp++; if (co !== 32'd1) begin n_bad++; $display("FAIL e0_c got=%0d exp=1", co); end
    n_cmp++; if (eo !== 1'b0) begin n_bad++; $display("FAIL e0_err got=%b exp=0", eo); end
    n_cmp++; if (lat != xl) begin n_bad++; $display("FAIL e0_lat got=%0d exp=%0d", lat, xl); end
    do_op(32'd0, 32'd7, 32'd13, co, eo, lat);
    n_cmp++; if (co !== 32'd0) begin n_bad++; $display("FAIL g0_c got=%0d exp=0", co); end
    n_cmp++; if (eo !== 1'b0) begin n_bad++; $display("FAIL g0_err got=%b exp=0", eo); end
    do_op(32'd2, 32'd3, 32'd13, co, eo, lat);
    n_cmp++; if (co !== 32'd8) begin n_bad++; $display("FAIL small_c got=%0d exp=8", co); end
  endtask

  task automatic test_err();
    logic [31:0] co; logic eo; int lat;
    do_op(32'd0, 32'd5, 32'd1, co, eo, lat);
    n_cmp++; if (eo !== 1'b1) begin n_bad++; $display("FAIL r1_err got=%b exp=1", eo); end
    n_cmp++; if (co !== 32'd0) begin n_bad++; $display("FAIL r1_c got=%0d exp=0", co); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL r1_lat got=%0d exp=1", lat); end
    do_op(32'd13, 32'd5, 32'd13, co, eo, lat);
    n_cmp++; if (eo !== 1'b1) begin n_bad++; $display("FAIL geqr_err got=%b exp=1", eo); end
    n_cmp++; if (co !== 32'd0) begin n_bad++; $display("FAIL geqr_c got=%0d exp=0", co); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL geqr_lat got=%0d exp=1", lat); end
  endtask

  task automatic test_ignore_start();
    int lat, xl;
    xl = CT ? LAT_CT : 1057;
    @(negedge clk);
    g = 32'd3; e = 32'd4; r = P; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    while (!done && lat < LIMIT) begin
      if (lat == 50) begin g = 32'd13; e = 32'd9; r = 32'd1; start = 1'b1; end
      if (lat == 52) begin
        start = 1'b0;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ign_ready got=%b exp=0", ready); end
      end
      @(posedge clk);
      lat++;
      #1;
    end
    n_cmp++; if (c !== 32'd81) begin n_bad++; $display("FAIL ign_c got=%0d exp=81", c); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ign_err got=%b exp=0", err); end
    n_cmp++; if (lat != xl) begin n_bad++; $display("FAIL ign_lat got=%0d exp=%0d", lat, xl); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] co; logic eo; int lat, seen;
    @(negedge clk);
    g = 32'd3; e = 32'd4; r = P; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got=%b exp=1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got=%b exp=0", done); end
    n_cmp++; if (c !== 32'd0) begin n_bad++; $display("FAIL mid_c got=%0d exp=0", c); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_nodone got=%0d exp=0", seen); end
    do_op(32'd3, 32'd4, P, co, eo, lat);
    n_cmp++; if (co !== 32'd81) begin n_bad++; $display("FAIL mid_after_c got=%0d exp=81", co); end
  endtask

  task automatic test_back_to_back();
    int lat, xl;
    xl = CT ? LAT_CT : 1089;
    @(negedge clk);
    g = 32'd3; e = 32'd4; r = P; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    while (!done && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
    end
    n_cmp++; if (c !== 32'd81) begin n_bad++; $display("FAIL b2b_first_c got=%0d exp=81", c); end
    g = 32'd2; e = 32'd3; r = 32'd13;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got=%b exp=0", ready); end
    n_cmp++; if (c !== 32'd81) begin n_bad++; $display("FAIL b2b_hold_c got=%0d exp=81", c); end
    while (!done && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
    end
    n_cmp++; if (c !== 32'd8) begin n_bad++; $display("FAIL b2b_second_c got=%0d exp=8", c); end
    n_cmp++; if (lat != xl) begin n_bad++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, xl); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_done got=%b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fermat();
    test_edges();
    test_err();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
